zap_regf_wr_sched: RTL

//  Write-port scheduler and post-reset initialiser for the dual-write/quad-read register file.

---
 rtl/zap_regf_wr_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/zap_regf_wr_sched.sv
// ---------------------------------------------------------------------------
// zap_regf_wr_sched
// Write-port scheduler and post-reset initialiser for the dual-write /
// quad-read register file. Once out of reset it first walks the file two
// entries per cycle writing zero. Only then does it open the two write ports
// to the three writeback sources.
//
// Ports
//   i_clk, i_reset               core clock, synchronous active-high reset
//   i_ex_*   (valid/addr/data)   R0 execute writeback, never backpressured
//   i_mem_*  / o_mem_ready       R1 load-return writeback, valid/ready
//   i_dbg_*  / o_dbg_ready       R2 debug/host write, valid/ready
//   o_wen                        shared write enable for both ports
//   o_wr_addr_a/o_wr_data_a      write port A
//   o_wr_addr_b/o_wr_data_b      write port B (B wins on equal address)
//   o_init_done                  clear sequence finished, file is live
//   o_proto_err                  sticky: R0 presented before o_init_done
// ---------------------------------------------------------------------------
module zap_regf_wr_sched #(
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 40,
  parameter int STARVE_LIM = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ex_valid,
  input  logic [ADDR_W-1:0] i_ex_addr,
  input  logic [31:0]       i_ex_data,
  input  logic              i_mem_valid,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [31:0]       i_mem_data,
  output logic              o_mem_ready,
  input  logic              i_dbg_valid,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [31:0]       i_dbg_data,
  output logic              o_dbg_ready,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_wr_addr_a,
  output logic [31:0]       o_wr_data_a,
  output logic [ADDR_W-1:0] o_wr_addr_b,
  output logic [31:0]       o_wr_data_b,
  output logic              o_init_done,
  output logic              o_proto_err
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_LIM);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, err_q;

  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [31:0]       data_a_q, data_a_d, data_b_q, data_b_d;

  logic open_run, force_dbg;
  logic grant_ex, grant_mem, grant_dbg;
  logic mem_rdy, dbg_rdy;

  // State register plus the clear pointer, starvation counter and the
  // registered write-port outputs. Any reset restarts the clear from entry 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      state_q  <= state_d;
      if (state_q == CLEAR)
        ptr_q <= ptr_q + ADDR_W'(2);
      cnt_q    <= cnt_d;
      // done rises the cycle after the last clear pair has been written
      done_q   <= (state_q == RUN);
      err_q    <= err_q | (i_ex_valid & ~done_q);
      wen_q    <= wen_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  // Leave CLEAR once the final pair (DEPTH-2, DEPTH-1) is being written.
  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && ptr_q == LAST_PAIR)
      state_d = RUN;
  end

  // Grant, ready and port-steering logic. The file only opens once done is
  // visible, so the pipeline never sees a ready before o_init_done.
  // When R2 has starved for STARVE_LIM cycles R1 is held off and its slot is
  // handed to R2; R2 still yields to any granted address it collides with.
  always_comb begin
    open_run  = (state_q == RUN) && done_q;
    force_dbg = (cnt_q == CNT_MAX);
    grant_ex  = open_run & i_ex_valid;
    mem_rdy   = open_run & ~force_dbg;
    grant_mem = mem_rdy & i_mem_valid;
    dbg_rdy   = open_run
              & ~(grant_ex & grant_mem)
              & ~(grant_ex  && (i_dbg_addr == i_ex_addr))
              & ~(grant_mem && (i_dbg_addr == i_mem_addr));
    grant_dbg = dbg_rdy & i_dbg_valid;

    cnt_d = '0;
    if (open_run && i_dbg_valid && !dbg_rdy)
      cnt_d = force_dbg ? cnt_q : cnt_q + CNT_W'(1);

    wen_d    = 1'b0;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (state_q == CLEAR) begin
      wen_d    = 1'b1;
      addr_a_d = ptr_q;
      addr_b_d = ptr_q + ADDR_W'(1);
      data_a_d = '0;
      data_b_d = '0;
    end else if (grant_ex) begin
      // R0 on A; B carries the later source, or mirrors R0 when alone
      wen_d    = 1'b1;
      addr_a_d = i_ex_addr;
      data_a_d = i_ex_data;
      addr_b_d = grant_mem ? i_mem_addr : (grant_dbg ? i_dbg_addr : i_ex_addr);
      data_b_d = grant_mem ? i_mem_data : (grant_dbg ? i_dbg_data : i_ex_data);
    end else if (grant_mem) begin
      wen_d    = 1'b1;
      addr_b_d = i_mem_addr;
      data_b_d = i_mem_data;
      addr_a_d = grant_dbg ? i_dbg_addr : i_mem_addr;
      data_a_d = grant_dbg ? i_dbg_data : i_mem_data;
    end else if (grant_dbg) begin
      wen_d    = 1'b1;
      addr_a_d = i_dbg_addr;
      data_a_d = i_dbg_data;
      addr_b_d = i_dbg_addr;
      data_b_d = i_dbg_data;
    end
  end

  assign o_mem_ready = mem_rdy;
  assign o_dbg_ready = dbg_rdy;
  assign o_wen       = wen_q;
  assign o_wr_addr_a = addr_a_q;
  assign o_wr_data_a = data_a_q;
  assign o_wr_addr_b = addr_b_q;
  assign o_wr_data_b = data_b_q;
  assign o_init_done = done_q;
  assign o_proto_err = err_q;

endmodule
